// File: rtl/imem_resp.sv
// -----------------------------------------------------------------------------
// imem_resp
// Instruction-memory responder sitting on the memory side of the fetch
// interface. The PC unit issues fetch requests over a valid/ready handshake.
// The block reads a word-addressed ROM at the accept edge and delays the word
// through a fixed-latency pipe. It then queues the word in a small response
// FIFO, which returns instructions strictly in request order with
// back-pressure.
//
// Optional feature (compile-time macro): IMEM_BOUNDS_CHECK_EN
//   defined   : misaligned or out-of-window fetches return a nop with rsp_err=1
//   undefined : rsp_err is always 0, the index wraps modulo DEPTH_WORDS and
//               the two address LSBs are ignored
//
// Ports
//   clk        in   1       clock, all state on posedge
//   rst_n      in   1       asynchronous active-low reset
//   req_valid  in   1       fetch request valid
//   req_ready  out  1       block can accept a request this cycle
//   req_addr   in   ADDR_W  fetch byte address (PC)
//   rsp_valid  out  1       rsp_ins/rsp_err valid
//   rsp_ready  in   1       consumer takes the response this cycle
//   rsp_ins    out  32      instruction word
//   rsp_err    out  1       fetch fault flag
// -----------------------------------------------------------------------------
module imem_resp #(
  parameter int                ADDR_W      = 64,
  parameter int                DEPTH_WORDS = 4096,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = ADDR_W'(64'h8000_0000),
  parameter int                LATENCY     = 1,
  parameter int                MAX_OUTST   = 2,
  parameter string             INIT_FILE   = "imem.hex"
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_ins,
  output logic              rsp_err
);

  localparam int          IDX_W   = $clog2(DEPTH_WORDS);
  localparam int          PTR_W   = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  localparam int          CNT_W   = 3;
  localparam logic [31:0] NOP_INS = 32'h0000_0013;

  // ROM image; contents are never reset.
  logic [31:0] rom [DEPTH_WORDS];

  logic [CNT_W-1:0]  outst;
  logic              accept;
  logic              pop;
  logic [ADDR_W-1:0] offset;
  logic [IDX_W-1:0]  idx;
  logic [31:0]       in_ins;
  logic              in_err;

  logic              wr_valid;
  logic [31:0]       wr_ins;
  logic              wr_err;

  logic [31:0]       fifo_ins [MAX_OUTST];
  logic [MAX_OUTST-1:0] fifo_err;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  fifo_cnt;
  logic [31:0]       last_ins;
  logic              last_err;

  // outst covers both pipe and FIFO entries, so gating acceptance on it
  // guarantees the FIFO always has room for whatever leaves the pipe.
  assign req_ready = rst_n & (outst < CNT_W'(MAX_OUTST));
  assign accept    = req_valid & req_ready;
  assign pop       = rsp_valid & rsp_ready;

  assign offset = req_addr - BASE_ADDR;
  assign idx    = offset[IDX_W+1:2];

  // The word-select LSBs of the offset never matter: alignment is judged on
  // the raw address.
  logic unused_offset_lsbs;
  assign unused_offset_lsbs = ^offset[1:0];

`ifdef IMEM_BOUNDS_CHECK_EN
  // For addresses at or above BASE_ADDR the offset cannot wrap. Any set bit
  // above the index field therefore means the address is past the ROM window.
  logic fault;
  assign fault  = (req_addr[1:0] != 2'b00) |
                  (req_addr < BASE_ADDR) |
                  (offset[ADDR_W-1:IDX_W+2] != '0);
  assign in_ins = fault ? NOP_INS : rom[idx];
  assign in_err = fault;
`else
  logic unused_offset_msbs;
  assign unused_offset_msbs = ^offset[ADDR_W-1:IDX_W+2];
  assign in_ins = rom[idx];
  assign in_err = 1'b0;
`endif

  // The accept edge itself is the first of the LATENCY stages. With
  // LATENCY=1 the ROM word is written straight into the FIFO at that edge.
  // Otherwise LATENCY-1 extra registers sit in front of the FIFO.
  generate
    if (LATENCY == 1) begin : g_no_pipe
      assign wr_valid = accept;
      assign wr_ins   = in_ins;
      assign wr_err   = in_err;
    end else begin : g_pipe
      localparam int STAGES = LATENCY - 1;

      logic [STAGES-1:0] pipe_valid;
      logic [31:0]       pipe_ins [STAGES];
      logic [STAGES-1:0] pipe_err;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          pipe_valid <= '0;
        end else begin
          pipe_valid[0] <= accept;
          for (int i = 1; i < STAGES; i++) begin
            pipe_valid[i] <= pipe_valid[i-1];
          end
        end
      end

      always_ff @(posedge clk) begin
        pipe_ins[0] <= in_ins;
        pipe_err[0] <= in_err;
        for (int i = 1; i < STAGES; i++) begin
          pipe_ins[i] <= pipe_ins[i-1];
          pipe_err[i] <= pipe_err[i-1];
        end
      end

      assign wr_valid = pipe_valid[STAGES-1];
      assign wr_ins   = pipe_ins[STAGES-1];
      assign wr_err   = pipe_err[STAGES-1];
    end
  endgenerate

  // Pointers wrap modulo MAX_OUTST, which need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_OUTST - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outst <= '0;
    end else begin
      case ({accept, pop})
        2'b10:   outst <= outst + CNT_W'(1);
        2'b01:   outst <= outst - CNT_W'(1);
        default: outst <= outst;
      endcase
    end
  end

  // FIFO control. last_* remembers the most recently popped response so the
  // outputs hold their value while the FIFO is empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      last_ins <= '0;
      last_err <= 1'b0;
    end else begin
      if (wr_valid) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr   <= ptr_inc(rd_ptr);
        last_ins <= fifo_ins[rd_ptr];
        last_err <= fifo_err[rd_ptr];
      end
      case ({wr_valid, pop})
        2'b10:   fifo_cnt <= fifo_cnt + CNT_W'(1);
        2'b01:   fifo_cnt <= fifo_cnt - CNT_W'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_valid) begin
      fifo_ins[wr_ptr] <= wr_ins;
      fifo_err[wr_ptr] <= wr_err;
    end
  end

  assign rsp_valid = (fifo_cnt != '0);
  assign rsp_ins   = rsp_valid ? fifo_ins[rd_ptr] : last_ins;
  assign rsp_err   = rsp_valid ? fifo_err[rd_ptr] : last_err;

endmodule

// File: tb/tb_imem_resp.sv
// -----------------------------------------------------------------------------
// tb_imem_resp
// Self-checking bench for imem_resp. A queue-based reference model tracks
// every accepted fetch as an expected response. The response carries the
// edge at which it becomes visible. The model predicts req_ready, rsp_valid,
// rsp_ins and rsp_err each cycle from the fetch rules alone. Directed scenarios
// come first, followed by a randomized phase.
// -----------------------------------------------------------------------------
module tb_imem_resp;

  localparam int          ADDR_W = 64;
  localparam int          DEPTH  = 256;
  localparam int          LAT    = 1;
  localparam int          MAXO   = 2;
  localparam logic [63:0] BASE   = 64'h8000_0000;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [63:0] req_addr;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_ins;
  logic        rsp_err;

  imem_resp #(
    .ADDR_W      (ADDR_W),
    .DEPTH_WORDS (DEPTH),
    .BASE_ADDR   (BASE),
    .LATENCY     (LAT),
    .MAX_OUTST   (MAXO),
    .INIT_FILE   ("")
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_ins   (rsp_ins),
    .rsp_err   (rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] ins;
    logic        err;
    int          vis;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] rom_model [DEPTH];
  int          cyc;
  int          n_cmp;
  int          n_fail;
  logic        exp_ready;
  logic        exp_valid;

  // Expected response for a fetch accepted at edge number edge_n.
  function automatic exp_t predict(input logic [63:0] a, input int edge_n);
    exp_t        e;
    logic [63:0] word;
    word  = (a - BASE) >> 2;
    e.ins = rom_model[int'(word % 64'(DEPTH))];
    e.err = 1'b0;
`ifdef IMEM_BOUNDS_CHECK_EN
    if (a[1:0] != 2'b00 || a < BASE || a >= BASE + 64'(4 * DEPTH)) begin
      e.ins = 32'h0000_0013;
      e.err = 1'b1;
    end
`endif
    e.vis = edge_n + LAT - 1;
    return e;
  endfunction

  task automatic compare(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  // Checks the DUT outputs against the model at the current sample point.
  task automatic checkOutput(input string tag);
    exp_ready = rst_n && (exp_q.size() < MAXO);
    exp_valid = rst_n && (exp_q.size() > 0) && (exp_q[0].vis <= cyc);
    compare($sformatf("%s.req_ready", tag), 64'(req_ready), 64'(exp_ready));
    compare($sformatf("%s.rsp_valid", tag), 64'(rsp_valid), 64'(exp_valid));
    if (exp_valid) begin
      compare($sformatf("%s.rsp_ins", tag), 64'(rsp_ins), 64'(exp_q[0].ins));
      compare($sformatf("%s.rsp_err", tag), 64'(rsp_err), 64'(exp_q[0].err));
    end
    if (!rst_n) begin
      compare($sformatf("%s.rst_ins", tag), 64'(rsp_ins), 64'h0);
      compare($sformatf("%s.rst_err", tag), 64'(rsp_err), 64'h0);
    end
  endtask

  // One clock cycle: drive at negedge, check, then advance the model at posedge.
  task automatic applyStimulus(input logic rst, input logic v, input logic [63:0] a,
                               input logic rr, input string tag, output logic acc);
    logic pop_m;
    @(negedge clk);
    rst_n     = rst;
    req_valid = v;
    req_addr  = a;
    rsp_ready = rr;
    #1;
    if (!rst) exp_q.delete();
    checkOutput(tag);
    acc   = rst && v && exp_ready;
    pop_m = rst && exp_valid && rr;
    @(posedge clk);
    cyc++;
    if (rst_n) begin
      if (pop_m) void'(exp_q.pop_front());
      if (acc) exp_q.push_back(predict(a, cyc));
    end
  endtask

  // Hold a request until the model says it was accepted, within a cycle bound.
  task automatic issue(input logic [63:0] a, input logic rr, input string tag);
    logic acc;
    acc = 1'b0;
    for (int k = 0; k < 20 && !acc; k++) begin
      applyStimulus(1'b1, 1'b1, a, rr, tag, acc);
    end
    n_cmp++;
    assert (acc) else begin
      n_fail++;
      $error("[TB] FAIL %s.accept_timeout: observed 0 expected 1", tag);
    end
  endtask

  task automatic idle(input int n, input logic rr, input string tag);
    logic acc;
    for (int k = 0; k < n; k++) begin
      applyStimulus(1'b1, 1'b0, 64'h0, rr, tag, acc);
    end
  endtask

  initial begin
    logic        acc;
    logic [63:0] a;
    logic        v;
    logic        rr;
    logic        rst;

    n_cmp     = 0;
    n_fail    = 0;
    cyc       = 0;
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_addr  = '0;
    rsp_ready = 1'b0;

    for (int i = 0; i < DEPTH; i++) begin
      rom_model[i] = $urandom;
    end
    rom_model[0] = 32'h0010_0093;
    for (int i = 0; i < DEPTH; i++) begin
      dut.rom[i] = rom_model[i];
    end
    $display("[TB] ROM preloaded with %0d words", DEPTH);

    // Reset state.
    applyStimulus(1'b0, 1'b0, 64'h0, 1'b0, "reset", acc);
    applyStimulus(1'b0, 1'b1, BASE, 1'b1, "reset", acc);

    // Single fetch of ROM[0]; the response appears on the following cycle.
    issue(BASE, 1'b1, "single");
    @(negedge clk);
    #1;
    compare("single.const_valid", 64'(rsp_valid), 64'h1);
    compare("single.const_ins", 64'(rsp_ins), 64'h0010_0093);
    compare("single.const_err", 64'(rsp_err), 64'h0);
    idle(2, 1'b1, "single_drain");

    // Back-pressure: the third request is blocked until the head drains.
    issue(BASE, 1'b0, "bp0");
    issue(BASE + 64'd4, 1'b0, "bp1");
    applyStimulus(1'b1, 1'b1, BASE + 64'd8, 1'b0, "bp_block", acc);
    compare("bp_block.ready", 64'(req_ready), 64'h0);
    issue(BASE + 64'd8, 1'b1, "bp2");
    idle(3, 1'b1, "bp_drain");

    // Streaming: eight sequential PCs with the consumer always ready.
    for (int i = 0; i < 8; i++) begin
      issue(BASE + 64'(4 * i), 1'b1, $sformatf("stream%0d", i));
    end
    idle(3, 1'b1, "stream_drain");

    // Boundary addresses: misaligned, below base, one past the window.
    issue(BASE + 64'd2, 1'b1, "mis");
    issue(BASE - 64'd4, 1'b1, "below");
    issue(BASE + 64'(4 * DEPTH), 1'b1, "above");
    idle(3, 1'b1, "bound_drain");

    // Reset with two responses outstanding; none may reappear afterwards.
    issue(BASE + 64'd12, 1'b0, "rst_fill0");
    issue(BASE + 64'd16, 1'b0, "rst_fill1");
    applyStimulus(1'b0, 1'b1, BASE, 1'b1, "midreset", acc);
    applyStimulus(1'b0, 1'b0, BASE, 1'b1, "midreset", acc);
    idle(4, 1'b1, "post_reset");

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      v   = ($urandom_range(0, 2) != 0);
      rr  = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 99) != 0);
      case ($urandom_range(0, 5))
        0, 1, 2: a = BASE + 64'(4 * $urandom_range(0, DEPTH - 1));
        3:       a = BASE + 64'(4 * DEPTH) + 64'(4 * $urandom_range(0, 31));
        4:       a = BASE - 64'(4 * $urandom_range(1, 32));
        default: a = BASE + 64'(4 * $urandom_range(0, DEPTH - 1)) + 64'($urandom_range(1, 3));
      endcase
      applyStimulus(rst, v, a, rr, "rand", acc);
    end
    idle(6, 1'b1, "final_drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
